mode_cmd_sequencer: RTL and testbench

//  Front-end controller for the clock/edit/timer/stopwatch datapath. Synchronises and hold-qualifies the five

---
 rtl/mode_cmd_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_mode_cmd_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_cmd_sequencer.sv
// Button front end for the clock/edit/timer/stopwatch datapath: synchronises and
// hold-qualifies five buttons, grants one by priority, masks by mode and run
// state, and issues single-cycle commands. Also owns mode, run flags and the tick.
module mode_cmd_sequencer #(
  parameter int unsigned HOLD_CYCLES = 15_000_000,
  parameter int unsigned TICK_DIV    = 100_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_reset,
  input  logic       btn_mode,
  input  logic       btn_edit_shift,
  input  logic       btn_inc,
  input  logic       btn_start_stop,
  input  logic       tm_done,
  input  logic       sw_full,
  output logic [1:0] mode,
  output logic [3:0] mode_led,
  output logic       edit_place,
  output logic       cmd_clear,
  output logic       cmd_inc,
  output logic       mode_enter,
  output logic       tm_run,
  output logic       sw_run,
  output logic       tick,
  output logic       busy
);

  localparam int unsigned NBTN   = 5;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Button bit positions; lower index wins arbitration.
  localparam logic [2:0] B_RST  = 3'd0;
  localparam logic [2:0] B_MODE = 3'd1;
  localparam logic [2:0] B_EDIT = 3'd2;
  localparam logic [2:0] B_INC  = 3'd3;
  localparam logic [2:0] B_SS   = 3'd4;

  localparam logic [1:0] M_CLOCK = 2'd0;
  localparam logic [1:0] M_EDIT  = 2'd1;
  localparam logic [1:0] M_TIMER = 2'd2;
  localparam logic [1:0] M_SW    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_FIRE     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  state_t            state;
  logic [NBTN-1:0]   btn_raw;
  logic [NBTN-1:0]   sync1;
  logic [NBTN-1:0]   sync2;
  logic [NBTN-1:0]   legal_c;
  logic [NBTN-1:0]   req_c;
  logic [2:0]        gnt_c;
  logic [2:0]        grant_q;
  logic              pend_q;
  logic              mode_chg_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [1:0]        mode_nxt_c;
  logic              gnt_hi_c;

  assign btn_raw    = {btn_start_stop, btn_inc, btn_edit_shift, btn_mode, btn_reset};
  assign req_c      = sync2 & legal_c;
  assign gnt_hi_c   = sync2[grant_q];
  assign mode_nxt_c = mode + 2'd1;

  function automatic logic [3:0] led_of(input logic [1:0] m);
    led_of = 4'b1000 >> m;
  endfunction

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Buttons allowed in the current mode and run state.
  always_comb begin
    legal_c = '0;
    case (mode)
      M_CLOCK: legal_c = 5'b00010;
      M_EDIT:  legal_c = 5'b01111;
      M_TIMER: legal_c = tm_run ? 5'b10000 : 5'b11111;
      M_SW:    legal_c = sw_run ? 5'b10000 : 5'b10011;
      default: legal_c = '0;
    endcase
  end

  // Fixed-priority pick among legal requests.
  always_comb begin
    gnt_c = B_RST;
    if      (req_c[B_RST])  gnt_c = B_RST;
    else if (req_c[B_MODE]) gnt_c = B_MODE;
    else if (req_c[B_EDIT]) gnt_c = B_EDIT;
    else if (req_c[B_INC])  gnt_c = B_INC;
    else if (req_c[B_SS])   gnt_c = B_SS;
  end

  // Arbiter FSM with hold qualification, command pulses and mode/run state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      grant_q    <= B_RST;
      pend_q     <= 1'b0;
      mode_chg_q <= 1'b0;
      hold_cnt   <= '0;
      mode       <= M_CLOCK;
      mode_led   <= 4'b1000;
      edit_place <= 1'b1;
      cmd_clear  <= 1'b0;
      cmd_inc    <= 1'b0;
      mode_enter <= 1'b0;
      tm_run     <= 1'b0;
      sw_run     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cmd_clear  <= 1'b0;
      cmd_inc    <= 1'b0;
      mode_enter <= mode_chg_q;
      mode_chg_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_c) begin
            grant_q  <= gnt_c;
            hold_cnt <= HOLD_W'(1);
            state    <= S_HOLD;
            busy     <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!gnt_hi_c) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            busy     <= 1'b0;
          end else begin
            if (hold_cnt != HOLD_W'(HOLD_CYCLES)) hold_cnt <= hold_cnt + HOLD_W'(1);
            // Count reaches HOLD_CYCLES on this edge: the command fires now.
            if (hold_cnt >= HOLD_W'(HOLD_CYCLES - 1)) begin
              state <= S_FIRE;
              case (grant_q)
                B_RST:   cmd_clear  <= 1'b1;
                B_INC:   cmd_inc    <= 1'b1;
                B_EDIT:  edit_place <= ~edit_place;
                default: pend_q     <= 1'b1;
              endcase
            end
          end
        end
        S_FIRE: begin
          state <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          // Deferred actions commit only once every button is released.
          if (sync2 == '0) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            hold_cnt <= '0;
            pend_q   <= 1'b0;
            if (pend_q) begin
              if (grant_q == B_MODE) begin
                mode       <= mode_nxt_c;
                mode_led   <= led_of(mode_nxt_c);
                tm_run     <= 1'b0;
                sw_run     <= 1'b0;
                mode_chg_q <= 1'b1;
              end else if (mode == M_TIMER) begin
                tm_run <= ~tm_run;
              end else if (mode == M_SW) begin
                sw_run <= ~sw_run;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // Datapath stop conditions override any coincident start.
      if (tm_done) tm_run <= 1'b0;
      if (sw_full) sw_run <= 1'b0;
    end
  end

  // Free-running tick divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= (tick_cnt == TICK_W'(TICK_DIV - 1));
      if (tick_cnt == TICK_W'(TICK_DIV - 1)) tick_cnt <= '0;
      else                                   tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

endmodule

// File: tb/tb_mode_cmd_sequencer.sv
// Directed bench for mode_cmd_sequencer with short hold and tick periods.
module tb_mode_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_reset = 1'b0, btn_mode = 1'b0, btn_edit_shift = 1'b0;
  logic       btn_inc = 1'b0, btn_start_stop = 1'b0;
  logic       tm_done = 1'b0, sw_full = 1'b0;
  logic [1:0] mode;
  logic [3:0] mode_led;
  logic       edit_place, cmd_clear, cmd_inc, mode_enter, tm_run, sw_run, tick, busy;

  int errors = 0;
  int checks = 0;

  // Event counters sampled on the falling edge.
  int cyc = 0;
  int n_inc = 0, n_clear = 0, n_enter = 0, n_busy = 0;
  int chg_cyc = 0, enter_cyc = 0;
  logic [1:0] prev_mode = 2'd0;

  mode_cmd_sequencer #(.HOLD_CYCLES(4), .TICK_DIV(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_reset(btn_reset), .btn_mode(btn_mode), .btn_edit_shift(btn_edit_shift),
    .btn_inc(btn_inc), .btn_start_stop(btn_start_stop),
    .tm_done(tm_done), .sw_full(sw_full),
    .mode(mode), .mode_led(mode_led), .edit_place(edit_place),
    .cmd_clear(cmd_clear), .cmd_inc(cmd_inc), .mode_enter(mode_enter),
    .tm_run(tm_run), .sw_run(sw_run), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_inc)   n_inc   <= n_inc + 1;
    if (cmd_clear) n_clear <= n_clear + 1;
    if (busy)      n_busy  <= n_busy + 1;
    if (mode_enter) begin
      n_enter   <= n_enter + 1;
      enter_cyc <= cyc;
    end
    if (mode != prev_mode) chg_cyc <= cyc;
    prev_mode <= mode;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Bits: 0 reset, 1 mode, 2 edit_shift, 3 inc, 4 start_stop.
  task automatic drive(input logic [4:0] b);
    btn_reset      = b[0];
    btn_mode       = b[1];
    btn_edit_shift = b[2];
    btn_inc        = b[3];
    btn_start_stop = b[4];
  endtask

  task automatic press(input logic [4:0] b, input int n);
    @(negedge clk);
    drive(b);
    repeat (n) @(negedge clk);
    drive(5'b0);
    repeat (7) @(negedge clk);
  endtask

  task automatic test_reset();
    drive(5'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mode !== 2'd0 || mode_led !== 4'b1000 || edit_place !== 1'b1) begin
      errors++;
      $display("FAIL reset_mode: mode=%0d led=%b ep=%b, want 0 1000 1", mode, mode_led, edit_place);
    end
    checks++;
    if ({cmd_clear, cmd_inc, mode_enter, tm_run, sw_run, tick, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: clr=%b inc=%b ent=%b tm=%b sw=%b tick=%b busy=%b, want all 0",
               cmd_clear, cmd_inc, mode_enter, tm_run, sw_run, tick, busy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_tick();
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tick !== ((k % 10) == 0)) begin
        errors++;
        $display("FAIL tick_cycle%0d: tick=%b, want %b", k, tick, (k % 10) == 0);
      end
    end
  endtask

  task automatic test_mode();
    int b0, i0, e0;
    // inc is illegal in CLOCK: nothing happens, arbiter never leaves IDLE
    b0 = n_busy; i0 = n_inc;
    press(5'b01000, 6);
    checks++;
    if (n_busy != b0 || n_inc != i0) begin
      errors++;
      $display("FAIL clock_inc_masked: busy_cycles=%0d inc_pulses=%0d, want 0 0", n_busy - b0, n_inc - i0);
    end
    e0 = n_enter;
    press(5'b00010, 6);
    checks++;
    if (mode !== 2'd1 || mode_led !== 4'b0100) begin
      errors++;
      $display("FAIL mode_to_edit: mode=%0d led=%b, want 1 0100", mode, mode_led);
    end
    checks++;
    if (n_enter - e0 != 1 || enter_cyc - chg_cyc != 1) begin
      errors++;
      $display("FAIL mode_enter: pulses=%0d offset=%0d, want 1 1", n_enter - e0, enter_cyc - chg_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mode_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_inc_hold();
    int i0;
    i0 = n_inc;
    press(5'b01000, 3);
    checks++;
    if (n_inc - i0 != 0) begin
      errors++;
      $display("FAIL inc_short: pulses=%0d, want 0", n_inc - i0);
    end
    i0 = n_inc;
    press(5'b01000, 8);
    checks++;
    if (n_inc - i0 != 1) begin
      errors++;
      $display("FAIL inc_long: pulses=%0d, want 1", n_inc - i0);
    end
    // a very long hold still yields a single command
    i0 = n_inc;
    press(5'b01000, 40);
    checks++;
    if (n_inc - i0 != 1) begin
      errors++;
      $display("FAIL inc_no_repeat: pulses=%0d, want 1", n_inc - i0);
    end
  endtask

  task automatic test_edit_shift();
    press(5'b00100, 6);
    checks++;
    if (edit_place !== 1'b0) begin
      errors++;
      $display("FAIL edit_shift: edit_place=%b, want 0", edit_place);
    end
  endtask

  task automatic test_reset_inc();
    int c0, i0;
    c0 = n_clear; i0 = n_inc;
    @(negedge clk);
    drive(5'b01001);
    repeat (6) @(negedge clk);
    drive(5'b01000);
    repeat (10) @(negedge clk);
    checks++;
    if (n_clear - c0 != 1 || n_inc - i0 != 0) begin
      errors++;
      $display("FAIL reset_inc_combo: clear=%0d inc=%0d, want 1 0", n_clear - c0, n_inc - i0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_release: busy=%b, want 1", busy);
    end
    drive(5'b0);
    repeat (7) @(negedge clk);
    i0 = n_inc;
    press(5'b01000, 6);
    checks++;
    if (n_inc - i0 != 1 || n_clear - c0 != 1) begin
      errors++;
      $display("FAIL inc_after_release: inc=%0d clear=%0d, want 1 1", n_inc - i0, n_clear - c0);
    end
  endtask

  task automatic test_timer();
    press(5'b00010, 6);
    checks++;
    if (mode !== 2'd2 || mode_led !== 4'b0010 || edit_place !== 1'b0) begin
      errors++;
      $display("FAIL to_timer: mode=%0d led=%b ep=%b, want 2 0010 0", mode, mode_led, edit_place);
    end
    press(5'b10000, 6);
    checks++;
    if (tm_run !== 1'b1 || sw_run !== 1'b0) begin
      errors++;
      $display("FAIL timer_start: tm_run=%b sw_run=%b, want 1 0", tm_run, sw_run);
    end
    press(5'b00010, 6);
    checks++;
    if (mode !== 2'd2 || tm_run !== 1'b1) begin
      errors++;
      $display("FAIL timer_mode_masked: mode=%0d tm_run=%b, want 2 1", mode, tm_run);
    end
    @(negedge clk); tm_done = 1'b1;
    @(negedge clk); tm_done = 1'b0;
    checks++;
    if (tm_run !== 1'b0) begin
      errors++;
      $display("FAIL timer_done: tm_run=%b, want 0", tm_run);
    end
    // tm_done arrives on the same edge as the start commit
    @(negedge clk);
    drive(5'b10000);
    repeat (6) @(negedge clk);
    drive(5'b0);
    repeat (2) @(negedge clk);
    tm_done = 1'b1;
    @(negedge clk);
    tm_done = 1'b0;
    checks++;
    if (tm_run !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_wins: tm_run=%b busy=%b, want 0 0", tm_run, busy);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_stopwatch();
    press(5'b00010, 6);
    checks++;
    if (mode !== 2'd3 || mode_led !== 4'b0001) begin
      errors++;
      $display("FAIL to_stopwatch: mode=%0d led=%b, want 3 0001", mode, mode_led);
    end
    press(5'b10000, 6);
    checks++;
    if (sw_run !== 1'b1 || tm_run !== 1'b0) begin
      errors++;
      $display("FAIL sw_start: sw_run=%b tm_run=%b, want 1 0", sw_run, tm_run);
    end
    @(negedge clk); sw_full = 1'b1;
    @(negedge clk); sw_full = 1'b0;
    checks++;
    if (sw_run !== 1'b0) begin
      errors++;
      $display("FAIL sw_full_stop: sw_run=%b, want 0", sw_run);
    end
    press(5'b10000, 6);
    // start_stop held long enough to be in HOLD, then async reset
    @(negedge clk);
    drive(5'b10000);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sw_run !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hold: busy=%b sw_run=%b, want 1 1", busy, sw_run);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mode !== 2'd0 || mode_led !== 4'b1000 || edit_place !== 1'b1 || sw_run !== 1'b0 ||
        tm_run !== 1'b0 || busy !== 1'b0 || cmd_clear !== 1'b0 || cmd_inc !== 1'b0 ||
        mode_enter !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mode=%0d led=%b ep=%b sw=%b tm=%b busy=%b, want 0 1000 1 0 0 0",
               mode, mode_led, edit_place, sw_run, tm_run, busy);
    end
    drive(5'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (mode !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: mode=%0d busy=%b, want 0 0", mode, busy);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_mode();
    test_inc_hold();
    test_edit_shift();
    test_reset_inc();
    test_timer();
    test_stopwatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
